axi3_burst_addr_gen: RTL
========================

# axi3_burst_addr_gen

Per-beat address generator for AXI3 read and write address channels. It accepts one burst command (start address, length, size, burst type) over a valid/ready handshake and emits one beat descriptor per data beat: beat address, beat index, last flag and protocol-error flag. It sits directly downstream of the AR/AW channel decode in a slave or bridge and feeds the data-path stage that indexes memory or forms the R/W beats.

## Interface
- `ADDR_WIDTH`, default 32: address width in bits (≥ 13).
- `DATA_BYTES`, default 4: data bus width in bytes (power of two, 1..128).
- `clk`, in, 1: sole clock; all logic is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: command accepted when it is high together with `cmd_valid`.
- `cmd_addr`, in, `ADDR_WIDTH`: burst start address.
- `cmd_len`, in, 4: beats minus one (AXI3 AxLEN).
- `cmd_size`, in, 3: bytes-per-beat code, 2^size bytes (`burst_size_big_t`).
- `cmd_burst`, in, 2: `burst_type_t`; 2'b11 is reserved.
- `beat_valid`, out, 1: beat descriptor present.
- `beat_ready`, in, 1: beat consumed when it is high together with `beat_valid`.
- `beat_addr`, out, `ADDR_WIDTH`: byte address of the current beat.
- `beat_idx`, out, 4: beat number, 0..`cmd_len`.
- `beat_last`, out, 1: high on beat `cmd_len`.
- `beat_err`, out, 1: the burst is illegal; constant across all beats of that burst.

## Operation
- Two states:
  - IDLE: `beat_valid`=0.
  - BURST: `beat_valid`=1.
- Command capture.
  - `cmd_ready` = IDLE, or (BURST and `beat_valid`&`beat_ready`&`beat_last`).
  - A back-to-back command can therefore load on the last-beat handshake with no bubble.
  - On capture, the block registers the command, sets `beat_idx`=0 and `beat_addr`=`cmd_addr`, computes `beat_err`, and enters BURST.
- Beat advance happens on each `beat_valid`&`beat_ready`:
  - `beat_idx`+1.
  - `beat_addr` takes the next address.
  - After the last beat, the block goes to IDLE unless a new command is captured in the same cycle.
- Next address, with B = 2^size:
  - FIXED: the address is unchanged.
  - INCR: next = (cur with the low `size` bits cleared) + B. The first beat may be unaligned; later beats are aligned.
  - WRAP: the total is T = B × (len+1), and the lower bound is `cmd_addr` with the low log2(T) bits cleared. Next = cur + B; if next equals lower bound + T, next = lower bound.
  - All arithmetic is modulo 2^`ADDR_WIDTH`.
- `beat_err` is set when any of the following holds:
  - `cmd_burst`=2'b11.
  - `cmd_size` > log2(`DATA_BYTES`).
  - WRAP with `cmd_len` not in {1,3,7,15}.
  - WRAP with `cmd_addr` not aligned to B.
  - INCR whose aligned start + B×(len+1) crosses a 4 KB boundary.
- Error bursts still emit exactly `cmd_len`+1 beats, so the downstream stage can return SLVERR on every beat.
  - For error bursts, `beat_addr` is held at `cmd_addr`; they are treated as FIXED.

## Timing
- Reset (async assert, sync release) puts the block in IDLE with all registered outputs zero:
  - `beat_valid`=0, `beat_addr`=0, `beat_idx`=0, `beat_last`=0, `beat_err`=0.
  - `cmd_ready` is forced to 0 while `rst` is high.
- Latency: a command captured at edge N presents beat 0 at output from edge N (visible in cycle N+1).
- Throughput: one beat per cycle while `beat_ready`=1.
- A burst of L+1 beats occupies L+1 cycles, with no gap between bursts.
- Stall: while `beat_valid`=1 and `beat_ready`=0, all `beat_*` outputs are held stable.
- `cmd_ready` is combinational from the state and `beat_ready`; there is no combinational path from `cmd_valid` to any output.
- Reset asserted mid-burst aborts the burst immediately. No residual beats appear after release.
- `cmd_len`=0 produces a single beat with `beat_last`=1 in the same cycle.

## Test plan
- INCR: size=2, addr=0x1002, len=3, `beat_ready`=1 → addresses 0x1002, 0x1004, 0x1008, 0x100C; last on idx 3; err=0.
- WRAP: size=2, addr=0x1008, len=3 → addresses 0x1008, 0x100C, 0x1000, 0x1004; err=0.
- FIXED: addr=0x20, len=2, with `beat_ready` toggling 1,0,0,1,1 → three beats of 0x20, each held through its stall; last on the third.
- Errors:
  - burst=2'b11, addr=0x40, len=1 → 2 beats at 0x40, err=1.
  - INCR addr=0xFF8, size=2, len=3 → 4 beats, err=1.
  - WRAP len=2 → err=1.
- Back-to-back: a second command is valid throughout the first burst → it is captured on the first burst's last-beat handshake, and its beat 0 appears the next cycle with no gap.
- Reset: `rst` pulse during beat 1 of a 16-beat INCR → `beat_valid` drops asynchronously. After release, `cmd_ready`=1 and no beats are emitted until a new command.

Source files
------------

// File: rtl/axi3_burst_addr_gen.sv
// rtl/axi3_burst_addr_gen.sv - AXI3 per-beat address generator
// Takes one burst command and emits one address descriptor per data beat.
module axi3_burst_addr_gen #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_BYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [3:0]            cmd_len,
   input  logic [2:0]            cmd_size,
   input  logic [1:0]            cmd_burst,
   output logic                  beat_valid,
   input  logic                  beat_ready,
   output logic [ADDR_WIDTH-1:0] beat_addr,
   output logic [3:0]            beat_idx,
   output logic                  beat_last,
   output logic                  beat_err
);

   localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_BYTES));
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] wrap_mask_q, wrap_mask_d;
   logic [3:0]            idx_q, idx_d;
   logic [3:0]            len_q, len_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic                  err_q, err_d;

   logic [ADDR_WIDTH-1:0] cap_b, cap_bmask, cur_b, cur_bmask, next_addr;
   logic [12:0]           cap_total, cap_end;
   logic [11:0]           cap_low_mask;
   logic                  cap_err, wrap_len_ok, beat_fire, is_last, cap;

   always_comb begin
      // Burst geometry of the incoming command, used only at capture time
      cap_b        = ADDR_WIDTH'(1) << cmd_size;
      cap_bmask    = cap_b - ADDR_WIDTH'(1);
      cap_total    = 13'({1'b0, cmd_len} + 5'd1) << cmd_size;
      cap_low_mask = cap_bmask[11:0];
      cap_end      = {1'b0, cmd_addr[11:0] & ~cap_low_mask} + cap_total;
      wrap_len_ok  = (cmd_len == 4'd1) || (cmd_len == 4'd3) ||
                     (cmd_len == 4'd7) || (cmd_len == 4'd15);
      cap_err      = (cmd_burst == BURST_RSVD) || (cmd_size > SIZE_MAX) ||
                     ((cmd_burst == BURST_WRAP) &&
                      (!wrap_len_ok || ((cmd_addr & cap_bmask) != '0))) ||
                     ((cmd_burst == BURST_INCR) && (cap_end > 13'h1000));

      cur_b     = ADDR_WIDTH'(1) << size_q;
      cur_bmask = cur_b - ADDR_WIDTH'(1);
      case (burst_q)
         BURST_INCR: next_addr = (addr_q & ~cur_bmask) + cur_b;
         // Legal wraps are B-aligned with power-of-two totals, so wrapping is a masked add
         BURST_WRAP: next_addr = (addr_q & ~wrap_mask_q) | ((addr_q + cur_b) & wrap_mask_q);
         default:    next_addr = addr_q;
      endcase

      beat_fire = (state_q == S_BURST) && beat_ready;
      is_last   = (state_q == S_BURST) && (idx_q == len_q);
      cmd_ready = !rst && ((state_q == S_IDLE) || (beat_fire && is_last));
      cap       = cmd_valid && cmd_ready;

      state_d     = state_q;
      addr_d      = addr_q;
      wrap_mask_d = wrap_mask_q;
      idx_d       = idx_q;
      len_d       = len_q;
      size_d      = size_q;
      burst_d     = burst_q;
      err_d       = err_q;

      if (cap) begin
         state_d     = S_BURST;
         addr_d      = cmd_addr;
         wrap_mask_d = ADDR_WIDTH'(cap_total - 13'd1);
         idx_d       = 4'd0;
         len_d       = cmd_len;
         size_d      = cmd_size;
         burst_d     = cap_err ? BURST_FIXED : cmd_burst;
         err_d       = cap_err;
      end else if (beat_fire) begin
         if (is_last) begin
            state_d = S_IDLE;
         end else begin
            idx_d  = idx_q + 4'd1;
            addr_d = next_addr;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wrap_mask_q <= '0;
         idx_q       <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= BURST_FIXED;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wrap_mask_q <= wrap_mask_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         size_q      <= size_d;
         burst_q     <= burst_d;
         err_q       <= err_d;
      end
   end

   assign beat_valid = (state_q == S_BURST);
   assign beat_addr  = addr_q;
   assign beat_idx   = idx_q;
   assign beat_last  = is_last;
   assign beat_err   = err_q;

endmodule
